mult_rr_scheduler: RTL and testbench
====================================

Name: mult_rr_scheduler

Overview:
- Shares one 4x4 signed sequential multiplier (start-pulse in, single-cycle valid-pulse out, 8-bit result) among NREQ requesters.
- Arbitration is round-robin; one multiply is in flight at a time.
- The block latches and holds the operands, issues the start pulse, waits for valid, and returns the product with a done pulse.
- Sits between requester datapaths (e.g. filter/MAC sequencers) and the shared multiplier instance.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 15, max cycles in WAIT before abort (used only with MULT_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester request level
x_in  input  4*NREQ  signed multiplicand, requester i at [4i+3:4i]
y_in  input  4*NREQ  signed multiplier, requester i at [4i+3:4i]
done  output  NREQ  one-hot, one-cycle completion pulse
z_out  output  8  signed product; valid when any done bit is high, held until next done
busy  output  1  high in any state other than IDLE
m_start  output  1  start pulse to multiplier
m_x  output  4  operand X to multiplier, held stable ISSUE..WAIT
m_y  output  4  operand Y to multiplier, held stable ISSUE..WAIT
m_valid  input  1  multiplier completion pulse
m_z  input  8  multiplier result, sampled when m_valid=1
err  output  1  sticky timeout flag (0 when MULT_TIMEOUT_EN undefined)

Behaviour:
- Reset (async, rst=0): state=IDLE, rr pointer=0, done=0, z_out=0, busy=0, m_start=0, m_x=0, m_y=0, err=0, internal grant index=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req!=0, grant the first set bit searching upward from pointer, wrapping modulo NREQ.
  - Latch that requester's x/y into m_x/m_y and store the grant index; go to ISSUE.
  - If req==0, stay in IDLE.
- ISSUE: m_start=1 for exactly this one cycle; go to WAIT.
- WAIT:
  - m_start=0.
  - On m_valid=1, register m_z into z_out and go to RESP.
  - m_valid seen in IDLE, ISSUE or RESP is ignored.
- RESP:
  - done[grant]=1 for one cycle.
  - Pointer := (grant+1) mod NREQ.
  - Go to IDLE; req is not sampled in RESP.
- Latency: req sampled in IDLE at cycle T -> m_start at T+1 -> done at the cycle after m_valid. With the current multiplier, done occurs at T+7.
- Back-to-back throughput: one result per (multiplier latency + 3) cycles.
- Requester rules:
  - Hold req and operands until done.
  - Drop req in the cycle after done, or it is taken as a new request.
  - Dropping req before grant withdraws the request.
  - Dropping req after grant does not abort; done still pulses.
- Operand changes on x_in/y_in after grant have no effect; latched values are used.
- Fairness: a requester holding req is served within NREQ grants.
- Reset mid-operation: immediate return to reset values. An in-flight multiplier result arriving after reset is ignored because the state is IDLE.
- done is strictly one-hot or zero; busy=0 exactly in IDLE.

Optional Feature:
- Macro: MULT_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no m_valid, go to RESP with z_out=0 and set err=1.
  - err is sticky until reset.
  - done[grant] still pulses so the requester never hangs.
- Undefined: no counter; WAIT is unbounded; err tied 0.

Test Plan:
- Reset: assert rst=0 mid-WAIT -> all outputs 0 and state IDLE same cycle; a late m_valid produces no done.
- Single request: req=0001, x0=3, y0=-2 -> one m_start pulse, m_x=3, m_y=-2 held; done=0001 with z_out=8'hFA (-6).
- Signed extremes: req=0100, x2=-7, y2=7 -> done=0100, z_out=8'hCF (-49); x2=0, y2=-5 -> z_out=0.
- Round-robin: req=1111 held, each requester dropping req after its done -> done order 0001, 0010, 0100, 1000; then req=1001 with pointer=0 -> order 0001, 1000.
- Withdraw and operand change: req1 dropped before grant -> never granted; x0 changed after grant -> result uses the latched value.
- MULT_TIMEOUT_EN, TIMEOUT=15, m_valid stubbed low -> done pulses 16 cycles after m_start, z_out=0, err=1 persisting until rst=0.

Source files
------------

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one 4x4 signed sequential multiplier among NREQ requesters.
// Optional macro MULT_TIMEOUT_EN bounds WAIT to TIMEOUT cycles and raises a sticky err.
module mult_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   x_in,
    input  logic [4*NREQ-1:0]   y_in,
    output logic [NREQ-1:0]     done,
    output logic [7:0]          z_out,
    output logic                busy,
    output logic                m_start,
    output logic [3:0]          m_x,
    output logic [3:0]          m_y,
    input  logic                m_valid,
    input  logic [7:0]          m_z,
    output logic                err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             r_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_gidx;
    logic [NREQ-1:0]    r_done;
    logic [7:0]         r_z;
    logic               r_m_start;
    logic [3:0]         r_m_x;
    logic [3:0]         r_m_y;

    logic [3:0]         w_xa [NREQ];
    logic [3:0]         w_ya [NREQ];
    logic [IW-1:0]      w_gidx;
    logic [IW-1:0]      w_cand;
    logic [IW:0]        w_sum;
    logic [NREQ-1:0]    w_onehot;

    for (genvar i = 0; i < NREQ; i++) begin : g_ops
        assign w_xa[i] = x_in[4*i+3:4*i];
        assign w_ya[i] = y_in[4*i+3:4*i];
    end

    // Scan downward so the candidate closest above the pointer is written last and wins.
    always_comb begin
        w_gidx = '0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            w_sum  = {1'b0, r_ptr} + (IW+1)'(k);
            w_cand = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : IW'(w_sum);
            if (req[w_cand]) w_gidx = w_cand;
        end
    end

    always_comb begin
        w_onehot         = '0;
        w_onehot[r_gidx] = 1'b1;
    end

`ifdef MULT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT+1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gidx    <= '0;
            r_done    <= '0;
            r_z       <= '0;
            r_m_start <= 1'b0;
            r_m_x     <= '0;
            r_m_y     <= '0;
`ifdef MULT_TIMEOUT_EN
            r_cnt     <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gidx    <= w_gidx;
                        r_m_x     <= w_xa[w_gidx];
                        r_m_y     <= w_ya[w_gidx];
                        r_m_start <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_m_start <= 1'b0;
`ifdef MULT_TIMEOUT_EN
                    r_cnt     <= '0;
`endif
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (m_valid) begin
                        r_z     <= m_z;
                        r_done  <= w_onehot;
                        r_state <= RESP;
                    end
`ifdef MULT_TIMEOUT_EN
                    // Abort on the TIMEOUT-th silent WAIT cycle; requester still gets done.
                    else if (r_cnt == CW'(TIMEOUT-1)) begin
                        r_z     <= '0;
                        r_err   <= 1'b1;
                        r_done  <= w_onehot;
                        r_state <= RESP;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    r_done  <= '0;
                    r_ptr   <= (r_gidx == IW'(NREQ-1)) ? '0 : r_gidx + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign done    = r_done;
    assign z_out   = r_z;
    assign busy    = (r_state != IDLE);
    assign m_start = r_m_start;
    assign m_x     = r_m_x;
    assign m_y     = r_m_y;

`ifdef MULT_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler with a 5-cycle behavioural multiplier stub.
module tb_mult_rr_scheduler;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [4*NREQ-1:0] x_in = '0;
    logic [4*NREQ-1:0] y_in = '0;
    logic [NREQ-1:0]   done;
    logic [7:0]        z_out;
    logic              busy;
    logic              m_start;
    logic [3:0]        m_x;
    logic [3:0]        m_y;
    logic              m_valid = 1'b0;
    logic [7:0]        m_z = '0;
    logic              err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nstart = 0;
    int onehot_bad = 0;
    int mcnt = 0;
    bit mul_on = 1'b1;

    mult_rr_scheduler #(.NREQ(NREQ), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req(req), .x_in(x_in), .y_in(y_in),
        .done(done), .z_out(z_out), .busy(busy), .m_start(m_start),
        .m_x(m_x), .m_y(m_y), .m_valid(m_valid), .m_z(m_z), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Multiplier stub: valid 5 cycles after start, not affected by the scheduler reset.
    always @(negedge clk) begin
        logic signed [7:0] p;
        m_valid = 1'b0;
        if (mcnt != 0) begin
            mcnt--;
            if (mcnt == 0) begin
                p       = $signed(m_x) * $signed(m_y);
                m_z     = p;
                m_valid = 1'b1;
            end
        end else if (m_start && mul_on) begin
            mcnt = 5;
        end
        if (m_start) nstart++;
        if ((done & (done - 1'b1)) != 0) onehot_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] x, input logic [3:0] y);
        x_in[4*i +: 4] = x;
        y_in[4*i +: 4] = y;
    endtask

    task automatic wait_done(output logic [NREQ-1:0] d, output logic [7:0] z);
        bit found = 1'b0;
        d = '0;
        z = '0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (done != 0) begin
                d = done;
                z = z_out;
                found = 1'b1;
            end
        end
        chk("done_seen", 32'(found), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [NREQ-1:0] d;
    logic [7:0]      z;
    int              c0;
    int              s0;
    int              seen;

    initial begin
        // Reset values
        @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_z", z_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mstart", m_start, 0);
        chk("rst_mxy", {m_x, m_y}, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single request 3 * -2
        set_op(0, 4'd3, 4'hE);
        s0 = nstart;
        c0 = cyc;
        req = 4'b0001;
        @(negedge clk);
        chk("iss_start", m_start, 1);
        chk("iss_mx", m_x, 4'd3);
        chk("iss_my", m_y, 4'hE);
        chk("iss_busy", busy, 1);
        @(negedge clk);
        chk("wait_start", m_start, 0);
        chk("wait_mxy", {m_x, m_y}, {4'd3, 4'hE});
        wait_done(d, z);
        req = '0;
        chk("single_done", d, 4'b0001);
        chk("single_z", z, 8'hFA);
        chk("single_lat", cyc - c0, 7);
        chk("single_nstart", nstart - s0, 1);
        @(negedge clk);
        chk("post_done", done, 0);
        chk("hold_z", z_out, 8'hFA);
        chk("idle_busy", busy, 0);

        // Signed extremes on requester 2
        set_op(2, 4'h9, 4'h7);
        req = 4'b0100;
        wait_done(d, z);
        req = '0;
        chk("ext_done", d, 4'b0100);
        chk("ext_z", z, 8'hCF);
        @(negedge clk);
        set_op(2, 4'h0, 4'hB);
        req = 4'b0100;
        wait_done(d, z);
        req = '0;
        chk("zero_z", z, 8'h00);

        // Round-robin from pointer 0
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 4'(i + 1), 4'd2);
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            wait_done(d, z);
            req = req & ~d;
            chk($sformatf("rr_done%0d", i), d, 32'(1) << i);
            chk($sformatf("rr_z%0d", i), z, 32'(2 * (i + 1)));
        end
        @(negedge clk);
        set_op(0, 4'h8, 4'h8);
        set_op(3, 4'h7, 4'h8);
        req = 4'b1001;
        wait_done(d, z);
        req = req & ~d;
        chk("rr2_done0", d, 4'b0001);
        chk("rr2_z0", z, 8'h40);
        wait_done(d, z);
        req = req & ~d;
        chk("rr2_done1", d, 4'b1000);
        chk("rr2_z1", z, 8'hC8);

        // Withdraw requester 1 before grant; change x0 after grant
        @(negedge clk);
        set_op(0, 4'd2, 4'd3);
        set_op(1, 4'd1, 4'd1);
        req = 4'b0011;
        @(negedge clk);
        req = 4'b0001;
        set_op(0, 4'd7, 4'd3);
        wait_done(d, z);
        req = '0;
        chk("wd_done", d, 4'b0001);
        chk("wd_latched_z", z, 8'h06);
        seen = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done != 0) seen++;
        end
        chk("wd_no_grant", seen, 0);
        chk("wd_busy", busy, 0);

        // Reset in WAIT; late multiplier valid must be ignored
        set_op(0, 4'd5, 4'd3);
        req = 4'b0001;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        req = '0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mxy", {m_x, m_y}, 0);
        chk("mid_rst_z", z_out, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done != 0 || busy) seen++;
        end
        chk("late_valid_ignored", seen, 0);

`ifdef MULT_TIMEOUT_EN
        // Timeout with the multiplier silenced
        mul_on = 1'b0;
        set_op(0, 4'd3, 4'd3);
        req = 4'b0001;
        s0 = 0;
        for (int n = 0; n < 10 && s0 == 0; n++) begin
            @(negedge clk);
            if (m_start) s0 = 1;
        end
        chk("to_start_seen", s0, 1);
        c0 = cyc;
        wait_done(d, z);
        req = '0;
        chk("to_done", d, 4'b0001);
        chk("to_lat", cyc - c0, 16);
        chk("to_z", z, 0);
        chk("to_err", err, 1);
        repeat (5) @(negedge clk);
        chk("to_err_sticky", err, 1);
        rst = 1'b0;
        #1;
        chk("to_err_rst", err, 0);
        @(negedge clk);
        rst = 1'b1;
        mul_on = 1'b1;
`else
        chk("err_tied_low", err, 0);
`endif

        chk("done_onehot", onehot_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
